// File: rtl/sinc_decim_ctrl.sv
// rtl/sinc_decim_ctrl.sv - sinc3 decimator sequencer: bit gating, dump strobe, settle discard, valid/ready output
module sinc_decim_ctrl #(
  parameter int DATA_W       = 20,
  parameter int MAX_OSR_LOG2 = 8,
  parameter int ORDER        = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              stop,
  input  logic [3:0]        osr_log2,
  input  logic              bit_valid,
  input  logic [DATA_W-1:0] dif3_in,
  output logic              filt_ce,
  output logic              filt_clr,
  output logic              dump,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              overrun,
  output logic              busy
);

  localparam int SET_W = $clog2(ORDER + 1);
  localparam int OSR_W = MAX_OSR_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              osr_reg;
  logic [3:0]              osr_clamped;
  logic [MAX_OSR_LOG2-1:0] dec_cnt;
  logic [SET_W-1:0]        settle_cnt;
  logic                    cap_pend;
  logic [OSR_W-1:0]        osr_full;
  logic                    dec_last;

  always_comb begin
    osr_clamped = osr_log2;
    if (osr_log2 == 4'd0)
      osr_clamped = 4'd1;
    else if (osr_log2 > 4'(MAX_OSR_LOG2))
      osr_clamped = 4'(MAX_OSR_LOG2);
  end

  assign osr_full = OSR_W'(1) << osr_reg;
  assign dec_last = ({1'b0, dec_cnt} == (osr_full - OSR_W'(1)));
  assign busy     = (state != IDLE);

  // A restart clears the filter for one cycle and suppresses ce/dump in that cycle.
  always_comb begin
    state_nxt = state;
    filt_ce   = 1'b0;
    filt_clr  = 1'b0;
    dump      = 1'b0;
    case (state)
      IDLE: begin
        filt_clr = 1'b1;
        if (start && !stop)
          state_nxt = SETTLE;
      end
      default: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          filt_clr  = 1'b1;
          state_nxt = SETTLE;
        end else begin
          filt_ce = bit_valid;
          dump    = bit_valid && dec_last;
          if (state == SETTLE && dump && settle_cnt == SET_W'(ORDER - 1))
            state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      osr_reg    <= 4'd1;
      dec_cnt    <= '0;
      settle_cnt <= '0;
      cap_pend   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      overrun    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (stop) begin
        cap_pend  <= 1'b0;
        out_valid <= 1'b0;
      end else if (start) begin
        osr_reg    <= osr_clamped;
        dec_cnt    <= '0;
        settle_cnt <= '0;
        cap_pend   <= 1'b0;
        out_valid  <= 1'b0;
        overrun    <= 1'b0;
      end else if (state != IDLE) begin
        if (bit_valid)
          dec_cnt <= dec_last ? '0 : dec_cnt + 1'b1;
        if (dump && state == SETTLE)
          settle_cnt <= settle_cnt + 1'b1;
        cap_pend <= dump && (state == RUN);
        // dif3_in is valid the cycle after the dump; a held unconsumed word wins over the new one.
        if (cap_pend) begin
          if (!out_valid || out_ready) begin
            out_data  <= dif3_in;
            out_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sinc_decim_ctrl.sv
// tb/tb_sinc_decim_ctrl.sv - directed vector bench for sinc_decim_ctrl
module tb_sinc_decim_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, stop, bit_valid, out_ready;
  logic [3:0]  osr_log2;
  logic [19:0] dif3_in;
  logic        filt_ce, filt_clr, dump, out_valid, overrun, busy;
  logic [19:0] out_data;

  int n_vec = 0;
  int n_bad = 0;

  sinc_decim_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .osr_log2(osr_log2),
    .bit_valid(bit_valid), .dif3_in(dif3_in), .filt_ce(filt_ce),
    .filt_clr(filt_clr), .dump(dump), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .overrun(overrun), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        start, stop;
    logic [3:0]  osr;
    logic        bv;
    logic [19:0] dif;
    logic        rdy;
    logic        ce, clr, dmp, ov, ovr, bsy;
    logic [19:0] od;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic [3:0] o,
                       input logic b, input logic [19:0] d, input logic r);
    start = s; stop = p; osr_log2 = o; bit_valid = b; dif3_in = d; out_ready = r;
  endtask

  function automatic logic [25:0] obs();
    return {filt_ce, filt_clr, dump, out_valid, overrun, busy, out_data};
  endfunction

  initial begin
    // start stop osr bv dif rdy | ce clr dmp ov ovr bsy od  (OSR clamped to 2, gaps, overrun, stop)
    tbl[0]  = '{0,0,4'd0, 0,20'h0,     1, 0,1,0,0,0,0,20'h0};
    tbl[1]  = '{1,0,4'd0, 0,20'h0,     1, 0,1,0,0,0,0,20'h0};
    tbl[2]  = '{0,0,4'd0, 1,20'h0,     1, 1,0,0,0,0,1,20'h0};
    tbl[3]  = '{0,0,4'd0, 0,20'h0,     1, 0,0,0,0,0,1,20'h0};
    tbl[4]  = '{0,0,4'd0, 1,20'h0,     1, 1,0,1,0,0,1,20'h0};
    tbl[5]  = '{0,0,4'd0, 1,20'h0,     1, 1,0,0,0,0,1,20'h0};
    tbl[6]  = '{0,0,4'd0, 1,20'h0,     1, 1,0,1,0,0,1,20'h0};
    tbl[7]  = '{0,0,4'd0, 1,20'h0,     1, 1,0,0,0,0,1,20'h0};
    tbl[8]  = '{0,0,4'd0, 1,20'h0,     1, 1,0,1,0,0,1,20'h0};
    tbl[9]  = '{0,0,4'd0, 1,20'h5,     1, 1,0,0,0,0,1,20'h0};
    tbl[10] = '{0,0,4'd0, 1,20'h6,     1, 1,0,1,0,0,1,20'h0};
    tbl[11] = '{0,0,4'd0, 0,20'h123,   0, 0,0,0,0,0,1,20'h0};
    tbl[12] = '{0,0,4'd0, 1,20'h7,     0, 1,0,0,1,0,1,20'h123};
    tbl[13] = '{0,0,4'd0, 1,20'h8,     0, 1,0,1,1,0,1,20'h123};
    tbl[14] = '{0,0,4'd0, 0,20'hABCDE, 0, 0,0,0,1,0,1,20'h123};
    tbl[15] = '{0,0,4'd0, 0,20'h0,     1, 0,0,0,1,1,1,20'h123};
    tbl[16] = '{0,0,4'd0, 0,20'h0,     1, 0,0,0,0,1,1,20'h123};
    tbl[17] = '{0,1,4'd0, 0,20'h0,     1, 0,0,0,0,1,1,20'h123};
    tbl[18] = '{0,0,4'd0, 0,20'h0,     1, 0,1,0,0,1,0,20'h123};
    tbl[19] = '{1,1,4'd0, 0,20'h0,     1, 0,1,0,0,1,0,20'h123};
    tbl[20] = '{0,0,4'd0, 0,20'h0,     1, 0,1,0,0,1,0,20'h123};
    tbl[21] = '{1,0,4'd15,0,20'h0,     1, 0,1,0,0,1,0,20'h123};
    tbl[22] = '{0,0,4'd0, 0,20'h0,     1, 0,0,0,0,0,1,20'h123};

    RST = 1'b0;
    drive(0, 0, 4'd0, 1, 20'h0, 1);
    #1;
    chk("reset_outputs", 32'(obs()), 32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0}));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].osr, tbl[i].bv, tbl[i].dif, tbl[i].rdy);
      #1;
      chk($sformatf("row%0d", i), 32'(obs()),
          32'({tbl[i].ce, tbl[i].clr, tbl[i].dmp, tbl[i].ov, tbl[i].ovr, tbl[i].bsy, tbl[i].od}));
      @(negedge CLK);
    end

    // osr_log2=15 clamps to 256: exactly one dump after 256 counted bits
    for (int k = 0; k < 256; k++) begin
      drive(0, 0, 4'd0, 1, 20'h0, 1);
      #1;
      chk($sformatf("osr256_dump_k%0d", k), 32'(dump), 32'(k == 255));
      @(negedge CLK);
    end
    drive(0, 1, 4'd0, 0, 20'h0, 1);
    @(negedge CLK);

    // OSR=16, continuous bits: three discarded dumps, 4th captured 2 cycles later
    drive(1, 0, 4'd4, 0, 20'h0, 0);
    @(negedge CLK);
    for (int i = 0; i < 84; i++) begin
      drive(0, 0, 4'd0, 1, 20'(1000 + i), (i >= 82));
      #1;
      chk($sformatf("t2_dump_i%0d", i), 32'(dump), 32'(i % 16 == 15));
      if (i <= 64) chk($sformatf("t2_noval_i%0d", i), 32'(out_valid), 32'd0);
      if (i == 65) begin
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_data", 32'(out_data), 32'd1064);
      end
      if (i == 80) chk("t3_no_ovr_yet", 32'(overrun), 32'd0);
      if (i == 81) begin
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_held", 32'(out_data), 32'd1064);
      end
      if (i == 82) chk("t3_valid_before_ack", 32'(out_valid), 32'd1);
      if (i == 83) chk("t3_acked", 32'(out_valid), 32'd0);
      @(negedge CLK);
    end

    // restart in RUN, then a handshake coincident with a capture
    drive(1, 0, 4'd4, 1, 20'h0, 0);
    #1;
    chk("t5_restart_clr", 32'(filt_clr), 32'd1);
    @(negedge CLK);
    for (int j = 0; j < 82; j++) begin
      drive(0, 0, 4'd0, 1, 20'(2000 + j), (j == 80));
      #1;
      if (j == 0) begin
        chk("t5_clr_one_cycle", 32'(filt_clr), 32'd0);
        chk("t5_ovr_cleared", 32'(overrun), 32'd0);
        chk("t5_valid_cleared", 32'(out_valid), 32'd0);
      end
      if (j <= 64) chk($sformatf("t5_noval_j%0d", j), 32'(out_valid), 32'd0);
      if (j == 65) chk("t5_data1", 32'(out_data), 32'd2064);
      if (j == 81) begin
        chk("t5_hs_valid", 32'(out_valid), 32'd1);
        chk("t5_hs_data", 32'(out_data), 32'd2080);
        chk("t5_hs_no_ovr", 32'(overrun), 32'd0);
      end
      @(negedge CLK);
    end
    drive(0, 1, 4'd0, 1, 20'h0, 0);
    @(negedge CLK);
    #1;
    chk("t5_stop_idle", 32'({busy, out_valid}), 32'd0);
    @(negedge CLK);

    // asynchronous reset mid-RUN with a word pending
    drive(1, 0, 4'd1, 0, 20'h0, 0);
    @(negedge CLK);
    for (int j = 0; j < 10; j++) begin
      drive(0, 0, 4'd0, 1, 20'(3000 + j), 0);
      @(negedge CLK);
    end
    #1;
    chk("t1_pre_valid", 32'({out_valid, out_data}), 32'({1'b1, 20'd3008}));
    #1;
    RST = 1'b0;
    #1;
    chk("t1_async_outputs", 32'(obs()), 32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0}));
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("t1_idle_after", 32'({busy, filt_clr, filt_ce}), 32'({1'b0, 1'b1, 1'b0}));
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
